// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-enable patterns.
// The alignment rule lives here so the stage and any checker agree on it.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus: the MEM stage is master, the data memory is slave.
// Request fields are held stable by the master from request until the acknowledging edge.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dm_req;
  logic              dm_wr;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte-enables and replication, load lane extraction and extension.
// Halves use only off[1] and words ignore the offset, so misaligned inputs degrade to aligned accesses.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_off, 3'b000});
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be        = BE_ALL;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_off;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be        = i_off[1] ? BE_HI : BE_LO;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: memory ops finish k+1 cycles after entry (k = REQ cycles); others pass through same cycle.
// Stalls upstream while a request is open and holds DONE while WB stalls. Option: MEM_ALIGN_CHECK_EN.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              MEM_valid,
  input  logic              mem_load,
  input  logic              mem_store,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              cancel,
  input  logic              WB_allow_in,
  output logic              MEM_allow_in,
  output logic              MEM_over,
  output logic [DATA_W-1:0] mem_result,
  output logic              addr_exc,
  mem_access_if.master      dm
);

  state_t            r_state;
  state_t            w_next;
  logic              r_req;
  logic              r_wr;
  logic              r_is_load;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_lbuf;

  logic              w_idle;
  logic              w_memop;
  logic              w_misaligned;
  logic              w_start;
  logic              w_busy;
  logic              w_over;
  logic              w_exc;
  logic [DATA_W-1:0] w_result;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_uns;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_memop = mem_load | mem_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_memop & is_misaligned(mem_size, ex_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_start = MEM_valid & w_memop & ~w_misaligned & ~cancel;

  // Lane logic sees live inputs while issuing and the captured request while extracting read data.
  assign w_size = w_idle ? mem_size     : r_size;
  assign w_off  = w_idle ? ex_addr[1:0] : r_off;
  assign w_uns  = w_idle ? mem_unsigned : r_uns;

  mem_lane_align u_lane (
    .i_size       (w_size),
    .i_off        (w_off),
    .i_unsigned   (w_uns),
    .i_store_data (ex_store_data),
    .i_rdata      (dm.dm_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_REQ;
      ST_REQ: begin
        if (dm.dm_ack)   w_next = cancel ? ST_IDLE : ST_DONE;
        else if (cancel) w_next = ST_DRAIN;
      end
      ST_DONE:  if (WB_allow_in) w_next = ST_IDLE;
      ST_DRAIN: if (dm.dm_ack)   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_over   = 1'b0;
    w_exc    = 1'b0;
    w_busy   = 1'b0;
    w_result = ex_result;
    case (r_state)
      ST_IDLE: begin
        w_over = MEM_valid & ~cancel & (~w_memop | w_misaligned);
        w_exc  = MEM_valid & ~cancel & w_misaligned;
        if (w_misaligned) w_result = DATA_W'(ex_addr);
      end
      ST_REQ, ST_DRAIN: w_busy = 1'b1;
      ST_DONE: begin
        w_over = 1'b1;
        if (r_is_load) w_result = r_lbuf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_be      <= BE_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lbuf    <= '0;
      r_is_load <= 1'b0;
      r_uns     <= 1'b0;
      r_size    <= SZ_BYTE;
      r_off     <= 2'b00;
    end else begin
      if (w_idle && w_start) begin
        r_req     <= 1'b1;
        r_wr      <= mem_store;
        r_be      <= w_be;
        r_addr    <= {ex_addr[ADDR_W-1:2], 2'b00};
        r_wdata   <= w_wdata;
        r_is_load <= mem_load;
        r_uns     <= mem_unsigned;
        r_size    <= mem_size;
        r_off     <= ex_addr[1:0];
      end else if (w_busy && dm.dm_ack) begin
        r_req <= 1'b0;
      end
      // A cancelled load's data is dropped even if it returns on the cancelling edge.
      if ((r_state == ST_REQ) && dm.dm_ack && r_is_load && !cancel)
        r_lbuf <= w_load_data;
    end
  end

  assign dm.dm_req    = r_req;
  assign dm.dm_wr     = r_wr;
  assign dm.dm_be     = r_be;
  assign dm.dm_addr   = r_addr;
  assign dm.dm_wdata  = r_wdata;

  assign MEM_over     = w_over;
  assign addr_exc     = w_exc;
  assign mem_result   = w_result;
  assign MEM_allow_in = ~w_busy & (~MEM_valid | (w_over & WB_allow_in));

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, between EXE and WB. For loads and stores it runs a request/acknowledge transaction with a variable-latency data memory and merges byte lanes. It sign- or zero-extends load data and checks alignment. It presents a result and a completion strobe to the write-back stage; non-memory instructions pass through in one cycle.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock. One clock domain; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset
- MEM_valid  in  1  stage holds a valid instruction
- mem_load  in  1  instruction is a load
- mem_store  in  1  instruction is a store
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- mem_unsigned  in  1  zero-extend load data (lbu/lhu)
- ex_addr  in  32  effective byte address
- ex_store_data  in  32  store source (rt)
- ex_result  in  32  EXE result for non-memory instructions
- cancel  in  1  flush from WB (syscall/eret)
- WB_allow_in  in  1  WB can accept this cycle
- MEM_allow_in  out  1  stage can accept a new instruction
- MEM_over  out  1  stage result is valid this cycle
- mem_result  out  32  load data, or ex_result, or the faulting address
- addr_exc  out  1  misaligned access (only under MEM_ALIGN_CHECK_EN)
- dm_req  out  1  memory request
- dm_wr  out  1  1 = store
- dm_be  out  4  byte enables
- dm_addr  out  32  word address, low 2 bits forced to 0
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  request accepted / read data valid
- dm_rdata  in  32  read word, valid with dm_ack

## Operation
- FSM states:
  - IDLE: waiting; also handles non-memory and faulting instructions.
  - REQ: request outstanding.
  - DONE: result held for WB.
  - DRAIN: cancelled request still outstanding.
- start = MEM_valid & (mem_load | mem_store) & !misaligned & !cancel.
- IDLE + start → REQ. The request registers (dm_wr, dm_be, dm_addr, dm_wdata) are captured on this edge.
- IDLE, non-memory instruction: MEM_over = MEM_valid & !cancel, mem_result = ex_result.
- IDLE, misaligned access: no request is issued. MEM_over = 1, addr_exc = 1, mem_result = ex_addr.
- Misaligned means: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
- REQ + dm_ack → DONE. For a load, the extracted and extended value is registered into the load buffer.
- REQ + cancel → DRAIN. dm_req stays asserted until dm_ack; the result is discarded and the stage returns to IDLE.
- DONE: MEM_over = 1, mem_result = load buffer (loads) or ex_result (stores). DONE + WB_allow_in → IDLE.
- MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in). It is 0 in REQ and DRAIN.
- Store lanes:
  - byte: be = 1 << addr[1:0], wdata = {4{d[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - word: be = 1111.
- Load extract: byte lane rdata[8a+7:8a]; half lane selected by addr[1]. Extend with sign unless mem_unsigned.
- A store gated by cancel in its first cycle never reaches memory.

## Timing
- Reset values:
  - state = IDLE.
  - dm_req, dm_wr, MEM_over, addr_exc = 0.
  - dm_be = 0, dm_addr = 0, dm_wdata = 0, load buffer = 0.
- Reset asserted mid-transaction returns the stage to IDLE immediately. Memory-side recovery is the memory's responsibility.
- dm_req is registered. It first rises the cycle after entry and falls on the edge that samples dm_ack.
- dm_ack is valid in any REQ cycle, including the first.
- Memory op latency: entry cycle N, MEM_over at N+1+k, where k ≥ 1 is the number of REQ cycles.
- Non-memory latency: MEM_over in the entry cycle.
- Request registers stay stable throughout REQ and DRAIN.
- DONE with WB_allow_in = 0 holds mem_result and MEM_over unchanged.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misalignment detection and addr_exc are active.
- Undefined: addr_exc is tied to 0, and the access is forced aligned by ignoring the offending low address bits. Lane selection uses addr[1] for halves and nothing for words.

## Structure
- Shared package mem_pkg holds:
  - size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
  - FSM state enum
  - byte-enable constants
- One combinational sub-module, mem_lane_align, handles store replication/byte-enable generation and load extraction/extension. The FSM and registers stay in mem_access.

## Test plan
- lw at 0x100, ack after 3 cycles, rdata 0xDEADBEEF → dm_be 1111, MEM_over 4 cycles after entry, mem_result 0xDEADBEEF.
- lb at 0x103, rdata 0x80112233 → be 1000 (read), mem_result 0xFFFFFF80; lbu gives 0x00000080.
- sh at 0x202, data 0x0000ABCD → dm_be 1100, dm_wdata 0xABCDABCD, dm_addr 0x200, mem_result = ex_result.
- lw at 0x101 with MEM_ALIGN_CHECK_EN → no dm_req, addr_exc 1, mem_result 0x101, same-cycle MEM_over.
- sw arriving with cancel = 1 → dm_req never rises. Load cancelled in REQ → dm_req held to ack, no MEM_over.
- Load completes with WB_allow_in low for 2 cycles → result held stable, MEM_allow_in 0 until accepted.
